// File: rtl/dma_desc_sequencer.sv
// rtl/dma_desc_sequencer.sv - descriptor chain fetch, register load and engine launch sequencer
module dma_desc_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] desc_base,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_err,
  output logic [DATA_W-1:0] desc_data,
  output logic [3:0]        desc_sel,
  output logic              desc_we,
  input  logic [ADDR_W-1:0] next_desc,
  input  logic              eoc,
  output logic              eng_start,
  input  logic              eng_done,
  output logic              busy,
  output logic              chain_done,
  output logic              err,
  output logic [15:0]       desc_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    START = 3'd4,
    RUN   = 3'd5
  } state_t;

  localparam logic [2:0] LEN_FIELD = 3'd2;
  localparam logic [2:0] EOC_FIELD = 3'd4;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        idx;
  logic [DATA_W-1:0] data_q;
  logic              len_zero;

  logic [ADDR_W-1:0] field_off;
  logic              complete;

  // Field offset is idx words; the add truncates so a chain may wrap the address space.
  assign field_off = {{(ADDR_W-5){1'b0}}, idx, 2'b00};
  assign rd_addr   = cur_addr + field_off;

  // The register block sees the current field index and captured word continuously.
  assign desc_sel  = {1'b0, idx};
  assign desc_data = data_q;

  // A descriptor is finished either by the engine or immediately when it moves no data.
  assign complete = ((state == RUN) && eng_done) || ((state == START) && len_zero);

  // Sequencer FSM: pulse outputs default low each cycle and are set one cycle ahead
  // of the state in which they are meant to be seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cur_addr   <= '0;
      idx        <= '0;
      data_q     <= '0;
      len_zero   <= 1'b0;
      rd_req     <= 1'b0;
      desc_we    <= 1'b0;
      eng_start  <= 1'b0;
      busy       <= 1'b0;
      chain_done <= 1'b0;
      err        <= 1'b0;
      desc_count <= '0;
    end else begin
      desc_we    <= 1'b0;
      eng_start  <= 1'b0;
      chain_done <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= desc_base;
            idx        <= '0;
            desc_count <= '0;
            rd_req     <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          // rd_addr is a function of cur_addr/idx only, so it holds while stalled.
          if (rd_ready) begin
            rd_req <= 1'b0;
            state  <= WAIT;
          end
        end

        WAIT: begin
          if (rd_valid) begin
            if (rd_err) begin
              // Abort: fields already written stay in the register block.
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              data_q  <= rd_data;
              desc_we <= 1'b1;
              state   <= WRITE;
            end
          end
        end

        WRITE: begin
          if (idx == LEN_FIELD) begin
            len_zero <= (data_q == '0);
          end
          if (idx == EOC_FIELD) begin
            // len_zero was settled two fields earlier, so the launch decision is known now.
            eng_start <= !len_zero;
            state     <= START;
          end else begin
            idx    <= idx + 3'd1;
            rd_req <= 1'b1;
            state  <= REQ;
          end
        end

        START: begin
          // eng_done is not looked at here; only RUN accepts a completion pulse.
          if (!len_zero) begin
            state <= RUN;
          end
        end

        RUN: begin
          state <= RUN;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Completion overrides the per-state defaults above for START and RUN.
      if (complete) begin
        desc_count <= desc_count + 16'd1;
        if (eoc) begin
          chain_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end else begin
          cur_addr <= next_desc;
          idx      <= '0;
          rd_req   <= 1'b1;
          state    <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// tb/tb_dma_desc_sequencer.sv - scoreboard bench for dma_desc_sequencer
module tb_dma_desc_sequencer;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_ENG  = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    int          kind;
    logic [39:0] val;
  } ev_t;

  typedef logic [31:0] desc_t [5];

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] desc_base;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [31:0] desc_data;
  logic [3:0]  desc_sel;
  logic        desc_we;
  logic [31:0] next_desc;
  logic        eoc;
  logic        eng_start;
  logic        eng_done;
  logic        busy;
  logic        chain_done;
  logic        err;
  logic [15:0] desc_count;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  logic [31:0] mem [logic [31:0]];

  // memory responder configuration and state
  int          stall_cfg = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  // engine model configuration and state
  int          eng_lat = 3;
  int          eng_cnt = 0;
  logic        eng_coincide = 1'b0;
  // monitor bookkeeping
  int          cyc = 0;
  int          last_w4 = 0;
  logic        zl_check = 1'b0;

  dma_desc_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .desc_base(desc_base),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .desc_data(desc_data), .desc_sel(desc_sel), .desc_we(desc_we),
    .next_desc(next_desc), .eoc(eoc), .eng_start(eng_start),
    .eng_done(eng_done), .busy(busy), .chain_done(chain_done),
    .err(err), .desc_count(desc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic [39:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int k, input logic [39:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %h expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val !== v) begin
        errors++;
        $display("FAIL scoreboard: got kind %0d val %h expected kind %0d val %h", k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic load_desc(input logic [31:0] base, input desc_t w);
    for (int i = 0; i < 5; i++) mem[base + 32'(4 * i)] = w[i];
  endtask

  task automatic expect_desc(input logic [31:0] base, input desc_t w, input logic launch);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] sel;
      sel = 4'(i);
      push(K_RD, {8'h00, base + 32'(4 * i)});
      push(K_WR, {4'h0, sel, w[i]});
    end
    if (launch) push(K_ENG, '0);
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(posedge clk); #1;
    desc_base = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_eng(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!eng_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_eng_start", eng_start, 1);
  endtask

  // memory: single outstanding read, optional stall on next request, optional error address
  initial begin : mem_resp
    logic        pend;
    logic [31:0] pend_addr;
    logic        seen;
    logic [31:0] hold_addr;
    int          stall;
    pend = 1'b0; seen = 1'b0; stall = 0; pend_addr = '0; hold_addr = '0;
    rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
      rd_err   = 1'b0;
      rd_ready = 1'b0;
      if (!rstn) begin
        pend = 1'b0;
        seen = 1'b0;
      end else begin
        if (pend) begin
          rd_valid = 1'b1;
          rd_data  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
          rd_err   = err_en && (pend_addr == err_addr);
          pend     = 1'b0;
        end
        if (rd_req) begin
          if (!seen) begin
            seen      = 1'b1;
            hold_addr = rd_addr;
            stall     = stall_cfg;
            stall_cfg = 0;
          end else begin
            check("rd_addr_stable", rd_addr, hold_addr);
          end
          if (stall > 0) begin
            stall--;
          end else begin
            rd_ready  = 1'b1;
            pend      = 1'b1;
            pend_addr = rd_addr;
            seen      = 1'b0;
          end
        end else if (seen) begin
          check("rd_req_held", rd_req, 1);
          seen = 1'b0;
        end
      end
    end
  end

  // engine: eng_done eng_lat cycles after eng_start, optionally also in the START cycle
  initial begin : engine
    eng_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1'b1;
      end
      if (rstn && eng_start) begin
        if (eng_coincide) eng_done = 1'b1;
        eng_cnt = eng_lat;
      end
    end
  end

  // register block readback: latch NEXT and EOC fields as they are written
  initial begin : regblk
    next_desc = '0;
    eoc = 1'b0;
    forever begin
      @(negedge clk);
      if (desc_we && desc_sel == 4'd3) next_desc = desc_data;
      if (desc_we && desc_sel == 4'd4) eoc = desc_data[0];
    end
  end

  // monitor: every observable transaction is matched against the expected queue
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (rd_req && rd_ready) observe(K_RD, {8'h00, rd_addr});
        if (desc_we) begin
          observe(K_WR, {4'h0, desc_sel, desc_data});
          if (desc_sel == 4'd4) last_w4 = cyc;
        end
        if (eng_start) observe(K_ENG, '0);
        if (chain_done) begin
          observe(K_DONE, {24'h0, desc_count});
          if (zl_check) check("zero_len_done_latency", 64'(cyc - last_w4), 2);
        end
        if (err) observe(K_ERR, '0);
        if (chain_done && err) check("done_err_exclusive", 1, 0);
      end
    end
  end

  initial begin : stim
    desc_t d1, da, db, dz, de, dr, dw;
    start = 1'b0;
    desc_base = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_rd_req", rd_req, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_count", desc_count, 0);
    check("reset_pulses", {desc_we, eng_start, chain_done, err}, 0);
    rstn = 1'b1;

    // single descriptor
    d1 = '{32'h2000, 32'h3000, 32'd16, 32'h0, 32'h1};
    load_desc(32'h1000, d1);
    expect_desc(32'h1000, d1, 1'b1);
    push(K_DONE, 40'd1);
    pulse_start(32'h1000);
    check("busy_after_start", busy, 1);
    check("rd_req_after_start", rd_req, 1);
    wait_idle(300, "single_timeout");
    check("single_count", desc_count, 1);

    // two-descriptor chain with an ignored start mid-chain
    da = '{32'h4000, 32'h5000, 32'd8, 32'h1100, 32'h0};
    db = '{32'h6000, 32'h7000, 32'd4, 32'h0, 32'h1};
    load_desc(32'h1000, da);
    load_desc(32'h1100, db);
    expect_desc(32'h1000, da, 1'b1);
    expect_desc(32'h1100, db, 1'b1);
    push(K_DONE, 40'd2);
    pulse_start(32'h1000);
    fork
      wait_idle(500, "chain_timeout");
      begin
        repeat (20) @(posedge clk);
        #1;
        desc_base = 32'h9000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    check("chain_count", desc_count, 2);

    // zero-length descriptor: no launch, done two cycles after the EOC write
    dz = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h1};
    load_desc(32'h2000, dz);
    expect_desc(32'h2000, dz, 1'b0);
    push(K_DONE, 40'd1);
    zl_check = 1'b1;
    pulse_start(32'h2000);
    wait_idle(300, "zero_len_timeout");
    zl_check = 1'b0;

    // read error on field 2, then a clean restart
    de = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h1};
    load_desc(32'h3000, de);
    err_en = 1'b1;
    err_addr = 32'h3008;
    push(K_RD, {8'h00, 32'h3000});
    push(K_WR, {8'h00, 32'h11});
    push(K_RD, {8'h00, 32'h3004});
    push(K_WR, {8'h01, 32'h22});
    push(K_RD, {8'h00, 32'h3008});
    push(K_ERR, '0);
    pulse_start(32'h3000);
    wait_idle(300, "err_timeout");
    err_en = 1'b0;
    check("err_count", desc_count, 0);
    dr = de;
    expect_desc(32'h3000, dr, 1'b1);
    push(K_DONE, 40'd1);
    pulse_start(32'h3000);
    wait_idle(300, "restart_timeout");
    check("restart_count", desc_count, 1);

    // address wrap with a 5-cycle stall and an eng_done coincident with eng_start
    dw = '{32'hA, 32'hB, 32'h1, 32'h0, 32'h1};
    load_desc(32'hFFFF_FFF8, dw);
    expect_desc(32'hFFFF_FFF8, dw, 1'b1);
    push(K_DONE, 40'd1);
    stall_cfg = 5;
    eng_coincide = 1'b1;
    pulse_start(32'hFFFF_FFF8);
    wait_idle(300, "wrap_timeout");
    eng_coincide = 1'b0;
    check("wrap_count", desc_count, 1);

    // asynchronous reset while in RUN
    load_desc(32'h1000, d1);
    expect_desc(32'h1000, d1, 1'b1);
    eng_lat = 20;
    pulse_start(32'h1000);
    wait_eng(200);
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_run_busy", busy, 0);
    check("rst_run_rd", {rd_req, rd_addr}, 0);
    check("rst_run_desc", {desc_we, desc_sel, desc_data}, 0);
    check("rst_run_pulses", {eng_start, chain_done, err}, 0);
    check("rst_run_count", desc_count, 0);
    eng_cnt = 0;
    eng_lat = 3;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_idle", busy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
